// File: rtl/pulse_cdc_arbiter_pkg.sv
// pulse_cdc_pkg: shared types and defaults for pulse_cdc_arbiter.
//   state_t : fast-domain handshake FSM states
//   DEF_*   : default parameter values
//   id_w()  : requester-ID width, clog2 with a floor of 1
package pulse_cdc_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_IDLE = 2'd2
  } state_t;

  localparam int DEF_N_REQ       = 4;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  function automatic int id_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pulse_cdc_arbiter_if.sv
// pulse_cdc_arbiter_if: event/status bundle of pulse_cdc_arbiter.
//   req_pulse, ovf_clr, req_ovf, busy : clk_fast domain
//   evt_valid, evt_id                 : clk_slow domain
//   master: event source / consumer side; slave: the arbiter.
interface pulse_cdc_arbiter_if
  import pulse_cdc_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
);
  localparam int ID_W = id_w(N_REQ);

  logic [N_REQ-1:0] req_pulse;
  logic [N_REQ-1:0] ovf_clr;
  logic [N_REQ-1:0] req_ovf;
  logic             busy;
  logic             evt_valid;
  logic [ID_W-1:0]  evt_id;

  modport master (
    output req_pulse, ovf_clr,
    input  req_ovf, busy, evt_valid, evt_id
  );

  modport slave (
    input  req_pulse, ovf_clr,
    output req_ovf, busy, evt_valid, evt_id
  );
endinterface

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: SYNC_STAGES-deep single-bit synchronizer, async active-low reset.
//   clk, rst_n : destination clock / reset
//   d          : asynchronous input
//   q          : synchronized output
module cdc_sync_bit
  import pulse_cdc_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[SYNC_STAGES-2:0], d};
  end

  assign q = sr[SYNC_STAGES-1];
endmodule

// File: rtl/pulse_cdc_arbiter.sv
// pulse_cdc_arbiter: counts per-requester event pulses in clk_fast, arbitrates
// them and delivers one event at a time to clk_slow over a toggle req/ack
// handshake, emitting a one-cycle evt_valid strobe with the requester ID.
//   clk_fast, rst_n, clk_slow : clocks and shared async active-low reset
//   bus (slave)               : req_pulse/ovf_clr in, req_ovf/busy out (fast);
//                               evt_valid/evt_id out (slow)
// Build option: PULSE_CDC_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) instead of the default round-robin grant.
module pulse_cdc_arbiter
  import pulse_cdc_pkg::*;
#(
  parameter int N_REQ       = DEF_N_REQ,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic               clk_fast,
  input  logic               rst_n,
  input  logic               clk_slow,
  pulse_cdc_arbiter_if.slave bus
);
  localparam int ID_W = id_w(N_REQ);
  localparam int SW   = ID_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic [N_REQ-1:0] pend_vec;
  logic [N_REQ-1:0] ovf_vec;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  id_reg;
  logic             any_pend, grant_fire;
  logic             req_tog, ack_s;
  logic             req_s, req_s_d, ack_tog;
  logic             evt_valid_q;
  logic [ID_W-1:0]  evt_id_q;

  // Per-requester pending counter and sticky overflow flag
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             inc, dec, set_ovf;

    assign inc     = bus.req_pulse[i];
    assign dec     = grant_fire && (grant_idx == ID_W'(i));
    assign set_ovf = inc && !dec && (cnt == CNT_MAX);

    always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        if (inc && !dec) begin
          if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
        end else if (dec && !inc) begin
          cnt <= cnt - 1'b1;
        end
        if (set_ovf)              ovf <= 1'b1;
        else if (bus.ovf_clr[i])  ovf <= 1'b0;
      end
    end

    assign pend_vec[i] = (cnt != '0);
    assign ovf_vec[i]  = ovf;
  end

`ifdef PULSE_CDC_FIXED_PRIO_EN
  always_comb begin
    grant_idx = '0;
    any_pend  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!any_pend && pend_vec[ID_W'(k)]) begin
        any_pend  = 1'b1;
        grant_idx = ID_W'(k);
      end
    end
  end
`else
  logic [ID_W-1:0] rr_ptr;

  // Search upward from rr_ptr; the index wraps by one subtraction since
  // rr_ptr + k never exceeds 2*N_REQ-2.
  always_comb begin
    logic [SW-1:0] sum;
    sum       = '0;
    grant_idx = '0;
    any_pend  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(N_REQ)) sum = sum - SW'(N_REQ);
      if (!any_pend && pend_vec[sum[ID_W-1:0]]) begin
        any_pend  = 1'b1;
        grant_idx = sum[ID_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n)          rr_ptr <= '0;
    else if (grant_fire) rr_ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
  end
`endif

  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    grant_fire = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (any_pend) begin
          grant_fire = 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK:  if (ack_s == req_tog) state_d = WAIT_IDLE;
      WAIT_IDLE: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // id_reg is held from launch until IDLE, so clk_slow may sample it directly
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      id_reg  <= '0;
      req_tog <= 1'b0;
    end else if (grant_fire) begin
      id_reg  <= grant_idx;
      req_tog <= ~req_tog;
    end
  end

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .clk(clk_slow), .rst_n(rst_n), .d(req_tog), .q(req_s)
  );

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      req_s_d     <= 1'b0;
      ack_tog     <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
    end else begin
      req_s_d     <= req_s;
      ack_tog     <= req_s_d;
      evt_valid_q <= (req_s != req_s_d);
      if (req_s != req_s_d) evt_id_q <= id_reg;
    end
  end

  cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_ack_sync (
    .clk(clk_fast), .rst_n(rst_n), .d(ack_tog), .q(ack_s)
  );

  assign bus.req_ovf   = ovf_vec;
  assign bus.busy      = (state_q != IDLE);
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_id    = evt_id_q;
endmodule

// File: tb/tb_pulse_cdc_arbiter.sv
// tb_pulse_cdc_arbiter: scoreboard bench for pulse_cdc_arbiter.
// Each round drives a short pulse window (shorter than one handshake round
// trip, so only the first grant can fall inside it), predicts the delivered
// ID sequence from per-requester pending counts, then drains. A slow-domain
// monitor pops and compares every evt_valid strobe.
module tb_pulse_cdc_arbiter;
  import pulse_cdc_pkg::*;

  localparam int N_REQ       = 4;
  localparam int CNT_W       = 4;
  localparam int SYNC_STAGES = 2;
  localparam int ID_W        = id_w(N_REQ);
  localparam int CMAX        = (1 << CNT_W) - 1;
  localparam int MAXW        = 24;

  logic clk_fast = 1'b0;
  logic clk_slow = 1'b0;
  logic rst_n    = 1'b0;

  // 100 MHz fast, 25 MHz slow, phases chosen so edges never coincide
  always #5 clk_fast = ~clk_fast;
  initial begin
    #2;
    forever #20 clk_slow = ~clk_slow;
  end

  pulse_cdc_arbiter_if #(.N_REQ(N_REQ)) bus ();

  pulse_cdc_arbiter #(
    .N_REQ(N_REQ), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .clk_slow(clk_slow), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int mcnt [N_REQ];
  bit movf [N_REQ];
  int rr = 0;
  int exp_q [$];

  logic [N_REQ-1:0] pat [MAXW];
  logic [N_REQ-1:0] clr [MAXW];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pick();
    int start;
`ifdef PULSE_CDC_FIXED_PRIO_EN
    start = 0;
`else
    start = rr;
`endif
    for (int k = 0; k < N_REQ; k++) begin
      int i;
      i = (start + k) % N_REQ;
      if (mcnt[i] > 0) return i;
    end
    return -1;
  endfunction

  function automatic logic [N_REQ-1:0] ovf_vec();
    logic [N_REQ-1:0] v;
    for (int i = 0; i < N_REQ; i++) v[i] = movf[i];
    return v;
  endfunction

  task automatic clear_pat();
    for (int c = 0; c < MAXW; c++) begin
      pat[c] = '0;
      clr[c] = '0;
    end
  endtask

  // Model a round of w cycles, drive it, wait for delivery, check status.
  task automatic run_round(input int w, input string tag);
    bit granted;
    int g, t;
    granted = 1'b0;
    for (int c = 0; c <= w; c++) begin
      int gi;
      gi = -1;
      if (!granted) begin
        gi = pick();
        if (gi >= 0) begin
          granted = 1'b1;
          exp_q.push_back(gi);
          rr = (gi + 1) % N_REQ;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        bit inc, dec, set;
        inc = (c < w) && pat[c][i];
        dec = (gi == i);
        set = 1'b0;
        if (inc && !dec) begin
          if (mcnt[i] == CMAX) set = 1'b1;
          else mcnt[i]++;
        end else if (dec && !inc) begin
          mcnt[i]--;
        end
        if (set) movf[i] = 1'b1;
        else if ((c < w) && clr[c][i]) movf[i] = 1'b0;
      end
    end
    g = pick();
    while (g >= 0) begin
      exp_q.push_back(g);
      rr = (g + 1) % N_REQ;
      mcnt[g]--;
      g = pick();
    end

    for (int c = 0; c < w; c++) begin
      @(posedge clk_fast); #1;
      bus.req_pulse = pat[c];
      bus.ovf_clr   = clr[c];
    end
    @(posedge clk_fast); #1;
    bus.req_pulse = '0;
    bus.ovf_clr   = '0;

    t = 0;
    while (exp_q.size() > 0 && t < 5000) begin
      @(posedge clk_fast);
      t++;
    end
    check($sformatf("%s_pending_events", tag), exp_q.size(), 0);
    exp_q.delete();
    repeat (40) @(posedge clk_fast);
    @(negedge clk_fast);
    check($sformatf("%s_busy", tag), bus.busy, 0);
    check($sformatf("%s_req_ovf", tag), bus.req_ovf, ovf_vec());

    if (ovf_vec() != '0) begin
      @(posedge clk_fast); #1;
      bus.ovf_clr = '1;
      @(posedge clk_fast); #1;
      bus.ovf_clr = '0;
      for (int i = 0; i < N_REQ; i++) movf[i] = 1'b0;
      @(negedge clk_fast);
      check($sformatf("%s_ovf_cleared", tag), bus.req_ovf, 0);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk_slow) begin
    int e;
    if (rst_n && bus.evt_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_evt: got event id %0d, expected no event", bus.evt_id);
      end else begin
        e = exp_q.pop_front();
        check("evt_id", bus.evt_id, e);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_pulse = '0;
    bus.ovf_clr   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
    end
    repeat (4) @(posedge clk_fast);
    @(negedge clk_fast);
    check("rst_busy", bus.busy, 0);
    check("rst_req_ovf", bus.req_ovf, 0);
    check("rst_evt_valid", bus.evt_valid, 0);
    check("rst_evt_id", bus.evt_id, 0);
    @(posedge clk_fast); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk_fast);

    clear_pat(); pat[0] = 4'b0100;
    run_round(1, "single");

    clear_pat();
    for (int c = 0; c < 5; c++) pat[c] = 4'b0010;
    run_round(5, "burst");

    clear_pat();
    for (int c = 0; c < 12; c++) pat[c] = 4'b1111;
    run_round(12, "fair");

    // 17 pulses saturate the counter on the last one; clr in that cycle loses
    clear_pat();
    for (int c = 0; c < 17; c++) pat[c] = 4'b1000;
    clr[16] = 4'b1000;
    run_round(17, "ovf");

    clear_pat(); pat[0] = 4'b0001; pat[1] = 4'b0001;
    run_round(2, "simul");

    for (int r = 0; r < 20; r++) begin
      int w;
      clear_pat();
      w = $urandom_range(1, 12);
      for (int c = 0; c < w; c++) begin
        logic [N_REQ-1:0] v;
        for (int i = 0; i < N_REQ; i++) v[i] = ($urandom_range(0, 2) == 0);
        pat[c] = v;
        if ($urandom_range(0, 7) == 0) clr[c] = N_REQ'($urandom);
      end
      run_round(w, $sformatf("rand%0d", r));
    end

    // Reset while an event is in flight
    @(posedge clk_fast); #1;
    bus.req_pulse = 4'b0010;
    @(posedge clk_fast); #1;
    bus.req_pulse = 4'b0000;
    repeat (2) @(posedge clk_fast);
    @(negedge clk_fast);
    check("midflight_busy", bus.busy, 1);
    @(posedge clk_fast); #1;
    rst_n = 1'b0;
    exp_q.delete();
    rr = 0;
    for (int i = 0; i < N_REQ; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
    end
    @(negedge clk_fast);
    check("midrst_busy", bus.busy, 0);
    check("midrst_req_ovf", bus.req_ovf, 0);
    check("midrst_evt_valid", bus.evt_valid, 0);
    check("midrst_evt_id", bus.evt_id, 0);
    repeat (5) @(posedge clk_fast); #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk_fast);
    @(negedge clk_fast);
    check("postrst_busy", bus.busy, 0);

    clear_pat(); pat[0] = 4'b1111;
    run_round(1, "postrst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
